// File: rtl/vec_accu_stage.sv
// vec_accu_stage: lane-wise sum of a group of cache lines, held until the write stage takes it.
module vec_accu_stage #(
    parameter int CACHE_WIDTH = 512,
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CNT_WIDTH-1:0]   cfg_len,
    input  logic                   in_valid,
    input  logic [CACHE_WIDTH-1:0] in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [CACHE_WIDTH-1:0] out_data,
    input  logic                   out_ready,
    output logic [31:0]            grp_cnt,
    output logic                   busy
);
    localparam int LANES = CACHE_WIDTH / DATA_WIDTH;
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t                 r_state, w_next;
    logic [CNT_WIDTH-1:0]   r_len, r_beat, w_len_nxt, w_beat_nxt;
    logic [CACHE_WIDTH-1:0] r_acc, w_sum;
    logic [31:0]            r_grp;
    logic                   w_accept, w_last;
    assign w_accept   = in_valid && in_ready;
    assign w_len_nxt  = (r_state == IDLE) ? ((cfg_len == '0) ? CNT_WIDTH'(1) : cfg_len) : r_len;
    assign w_beat_nxt = (r_state == IDLE) ? CNT_WIDTH'(1) : r_beat + CNT_WIDTH'(1);
    assign w_last     = w_accept && (w_beat_nxt == w_len_nxt);
    // First beat of a group loads the line; later beats add into the running sum.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_sum[k*DATA_WIDTH +: DATA_WIDTH] =
            ((r_state == IDLE) ? DATA_WIDTH'(0) : r_acc[k*DATA_WIDTH +: DATA_WIDTH]) +
            in_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_last ? HOLD : (w_accept ? ACCUM : IDLE);
            ACCUM:   w_next = w_last ? HOLD : ACCUM;
            HOLD:    w_next = out_ready ? IDLE : HOLD;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        in_ready  = (r_state != HOLD);
        out_valid = (r_state == HOLD);
        busy      = (r_state != IDLE);
        out_data  = r_acc;
        grp_cnt   = r_grp;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc  <= '0;
            r_beat <= '0;
            r_len  <= '0;
            r_grp  <= '0;
        end else begin
            if (w_accept) begin
                r_acc  <= w_sum;
                r_beat <= w_beat_nxt;
                r_len  <= w_len_nxt;
            end
            if (out_valid && out_ready) r_grp <= r_grp + 32'd1;
        end
    end
endmodule

// File: tb/tb_vec_accu_stage.sv
// tb_vec_accu_stage: directed groups checked every cycle against a transaction-level sum model.
module tb_vec_accu_stage;
    localparam int L = 16;
    logic         clk = 0, rst = 0;
    logic [15:0]  cfg_len = '0;
    logic         in_valid = 0, out_ready = 1;
    logic [511:0] in_data = '0;
    logic         in_ready, out_valid, busy;
    logic [511:0] out_data;
    logic [31:0]  grp_cnt;
    int tests = 0, fails = 0;

    vec_accu_stage dut (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .grp_cnt(grp_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: lines collected into the open group, and whether a finished sum awaits the consumer.
    logic [31:0] m_acc [L];
    int          m_cnt = 0, m_len = 0;
    bit          m_pend = 0;
    logic [31:0] m_grp = 0;

    initial for (int i = 0; i < L; i++) m_acc[i] = 0;

    function automatic logic [511:0] m_vec();
        logic [511:0] v;
        for (int i = 0; i < L; i++) v[i*32 +: 32] = m_acc[i];
        return v;
    endfunction

    function automatic logic [511:0] fill(input logic [31:0] x);
        logic [511:0] v;
        for (int i = 0; i < L; i++) v[i*32 +: 32] = x;
        return v;
    endfunction

    always @(negedge rst) begin
        m_cnt = 0; m_pend = 0; m_grp = 0;
        for (int i = 0; i < L; i++) m_acc[i] = 0;
    end

    always @(posedge clk) if (rst) begin
        if (m_pend) begin
            if (out_ready) begin m_pend = 0; m_grp = m_grp + 1; end
        end else if (in_valid) begin
            if (m_cnt == 0) begin
                m_len = (cfg_len == 0) ? 1 : int'(cfg_len);
                for (int i = 0; i < L; i++) m_acc[i] = 0;
            end
            for (int i = 0; i < L; i++) m_acc[i] = m_acc[i] + in_data[i*32 +: 32];
            m_cnt++;
            if (m_cnt == m_len) begin m_pend = 1; m_cnt = 0; end
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("in_ready", 512'(in_ready), 512'(!m_pend));
        chk("out_valid", 512'(out_valid), 512'(m_pend));
        chk("busy", 512'(busy), 512'(m_pend || m_cnt > 0));
        chk("grp_cnt", 512'(grp_cnt), 512'(m_grp));
        if (m_pend) chk("out_data", out_data, m_vec());
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic put(input logic [511:0] d);
        bit r;
        int n;
        in_valid = 1; in_data = d; n = 0;
        do begin
            @(negedge clk); r = in_ready;
            @(posedge clk); #1; n++;
        end while (!r && n < 50);
        if (!r) chk("accept_timeout", 512'(0), 512'(1));
        in_valid = 0;
    endtask

    logic [511:0] va, vb, ve;

    initial begin
        step(2);
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_data", out_data, '0);
        rst = 1;
        step(1);
        // Four lines of 1..4 back to back: every lane sums to 10.
        cfg_len = 4;
        for (int v = 1; v <= 4; v++) put(fill(32'(v)));
        chk("s1_valid", 512'(out_valid), 512'(1));
        chk("s1_data", out_data, fill(32'd10));
        step(1);
        chk("s1_grp", 512'(grp_cnt), 512'(1));
        // Lane 0 wraps without carrying into lane 1.
        cfg_len = 2;
        for (int k = 0; k < L; k++) begin va[k*32 +: 32] = 32'(k); vb[k*32 +: 32] = 32'(k); ve[k*32 +: 32] = 32'(2*k); end
        va[31:0] = 32'hFFFF_FFFF; vb[31:0] = 32'd2; ve[31:0] = 32'd1;
        put(va); put(vb);
        chk("s2_data", out_data, ve);
        step(1);
        // Length 0 behaves as length 1.
        cfg_len = 0;
        put(fill(32'd7));
        chk("s3_valid", 512'(out_valid), 512'(1));
        chk("s3_data", out_data, fill(32'd7));
        step(1);
        chk("s3_grp", 512'(grp_cnt), 512'(3));
        // Back-pressure: a line offered during HOLD waits and opens the next group.
        cfg_len = 1; out_ready = 0;
        put(fill(32'd5));
        in_valid = 1; in_data = fill(32'd9);
        repeat (5) begin
            @(negedge clk);
            chk("s4_stall_ready", 512'(in_ready), 512'(0));
            chk("s4_stall_data", out_data, fill(32'd5));
            @(posedge clk); #1;
        end
        out_ready = 1;
        step(1);
        chk("s4_grp", 512'(grp_cnt), 512'(4));
        chk("s4_ready", 512'(in_ready), 512'(1));
        chk("s4_idle_valid", 512'(out_valid), 512'(0));
        step(1);
        in_valid = 0;
        chk("s4_next_valid", 512'(out_valid), 512'(1));
        chk("s4_next_data", out_data, fill(32'd9));
        step(1);
        chk("s4_grp2", 512'(grp_cnt), 512'(5));
        // Gaps between beats; the length latched at group start wins.
        cfg_len = 3;
        put(fill(32'd1)); step(2);
        cfg_len = 5;
        put(fill(32'd2)); step(3);
        chk("s5_mid_valid", 512'(out_valid), 512'(0));
        put(fill(32'd3));
        chk("s5_valid", 512'(out_valid), 512'(1));
        chk("s5_data", out_data, fill(32'd6));
        step(1);
        // Asynchronous reset mid-group discards the partial sum.
        cfg_len = 4;
        put(fill(32'd1)); put(fill(32'd2));
        #2 rst = 0;
        #1;
        chk("s6_busy", 512'(busy), 512'(0));
        chk("s6_data", out_data, '0);
        chk("s6_grp", 512'(grp_cnt), 512'(0));
        chk("s6_ready", 512'(in_ready), 512'(1));
        step(1);
        rst = 1;
        step(1);
        for (int v = 3; v <= 6; v++) put(fill(32'(v)));
        chk("s6_sum", out_data, fill(32'd18));
        step(1);
        chk("s6_grp2", 512'(grp_cnt), 512'(1));
        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vec_accu_stage.md
VEC_ACCU_STAGE -- requirements
Module: vec_accu_stage

Interface
REQ-001 SHALL have parameter CACHE_WIDTH, default 512, cache-line width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, lane width; LANES = CACHE_WIDTH/DATA_WIDTH (16).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of group-length and beat counters.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port cfg_len  input  CNT_WIDTH  number of lines summed per group.
REQ-007 SHALL have port in_valid  input  1  in_data holds a read-response line.
REQ-008 SHALL have port in_data  input  CACHE_WIDTH  line of LANES unsigned lanes, lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port in_ready  output  1  stage accepts a line this cycle.
REQ-010 SHALL have port out_valid  output  1  out_data holds a completed group sum.
REQ-011 SHALL have port out_data  output  CACHE_WIDTH  lane-wise sum of the group.
REQ-012 SHALL have port out_ready  input  1  consumer (write-request stage) takes out_data.
REQ-013 SHALL have port grp_cnt  output  32  groups delivered since reset.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, ACCUM, HOLD.
REQ-016 SHALL define accept = in_valid && in_ready; in_ready = 1 in IDLE and ACCUM, 0 in HOLD.
REQ-017 SHALL, on accept in IDLE, latch len = max(cfg_len,1), load acc with in_data, set beat = 1; cfg_len is ignored at all other times.
REQ-018 SHALL, on accept in ACCUM, set acc[k] = acc[k] + in_data[k] per lane, modulo 2^DATA_WIDTH, no carry between lanes, beat = beat + 1.
REQ-019 SHALL, when the accepted beat makes beat == len, move to HOLD; next cycle out_valid = 1 and out_data = final acc (latency 1 cycle from last accept).
REQ-020 SHALL, with len == 1, go IDLE -> HOLD on the single accept.
REQ-021 SHALL hold out_data and out_valid stable in HOLD until out_ready is high.
REQ-022 SHALL, on out_valid && out_ready, go to IDLE, clear out_valid and increment grp_cnt (wraps 2^32-1 -> 0) in the same edge; in_ready rises the following cycle (no bypass).
REQ-023 SHALL ignore in_valid when in_ready is 0; a line presented in HOLD is not consumed and not lost, since the producer must hold it.
REQ-024 SHALL stay in ACCUM with no change when in_valid = 0; no timeout.
REQ-025 SHALL drive busy = (state != IDLE).

Reset
REQ-026 SHALL, while rst = 0 and independent of clk, force state = IDLE, acc = 0, beat = 0, len = 0, out_valid = 0, out_data = 0, grp_cnt = 0; in_ready = 1 and busy = 0 follow from IDLE.
REQ-027 SHALL discard any partial group or pending output on reset mid-operation; after release the next accept starts a new group.
REQ-028 SHALL take first action on the first rising edge after rst deasserts.

Verification
REQ-029 SHALL cover: cfg_len = 4, lines with all lanes = 1, 2, 3, 4, back to back, out_ready = 1 -> one cycle after fourth accept out_valid = 1, every lane = 10, grp_cnt becomes 1.
REQ-030 SHALL cover: cfg_len = 2, lane 0 = 0xFFFFFFFF then 0x00000002, other lanes = k -> lane 0 = 0x00000001, lane k = 2k, no cross-lane carry.
REQ-031 SHALL cover: cfg_len = 0, one line of lanes = 7 -> treated as len 1; out_valid next cycle, lanes = 7.
REQ-032 SHALL cover: group complete, out_ready = 0 for 5 cycles with in_valid = 1 -> in_ready = 0, out_data stable, nothing consumed; out_ready = 1 -> grp_cnt + 1, in_ready = 1 one cycle later, held line becomes first beat of next group.
REQ-033 SHALL cover: cfg_len = 3, in_valid gaps between beats, cfg_len changed to 5 mid-group -> sum of exactly 3 lines emitted.
REQ-034 SHALL cover: rst pulsed low between clock edges after 2 of 4 beats -> outputs zero immediately; new 4-line group after release sums only post-reset lines.
